// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and sizes for the line/burst adaptor that sits
//                between the 2-way cache and physical memory.
//  Revision    : 1.0  initial release
// ============================================================================
package cache_pkg;

  // Adaptor control states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } adaptor_state_t;

  localparam int LINE_W      = 256;
  localparam int BURST_W     = 64;
  localparam int BEATS       = LINE_W / BURST_W;
  localparam int OFFSET_BITS = 5;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/line_burst_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : line_burst_adaptor
//  Description : Splits a 256-bit cache line into a 4 x 64-bit memory write
//                burst and reassembles 4 read beats into one line. One
//                resp_o pulse per completed line transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module line_burst_adaptor
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int                 CNT_W     = $clog2(BEATS);
  localparam logic [CNT_W-1:0]   LAST_BEAT = CNT_W'(BEATS - 1);
  // Clears the byte-offset bits so the memory sees a line-aligned address.
  localparam logic [31:0]        LINE_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  adaptor_state_t     r_state;
  adaptor_state_t     w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic [LINE_W-1:0]  r_line_wr;
  logic [LINE_W-1:0]  r_line_rd;
  logic [31:0]        r_addr;
  logic               w_last_beat;

  // A beat on the final index closes the burst.
  assign w_last_beat = resp_i && (r_count == LAST_BEAT);

  // State, beat counter, request latches and the assembled read line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_line_wr <= '0;
      r_line_rd <= '0;
      r_addr    <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          // Count restarts for every burst; resp_i is ignored here.
          r_count <= '0;
          if (write_i) begin
            r_line_wr <= line_i;
            r_addr    <= address_i & LINE_MASK;
          end else if (read_i) begin
            r_addr    <= address_i & LINE_MASK;
          end
        end
        RD_BURST: begin
          if (resp_i) begin
            r_line_rd[r_count*BURST_W +: BURST_W] <= burst_i;
            r_count <= r_count + 1'b1;
          end
        end
        WR_BURST: begin
          if (resp_i) begin
            r_count <= r_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and bus outputs derived from the current state.
  always_comb begin
    w_state_next = r_state;
    read_o       = 1'b0;
    write_o      = 1'b0;
    resp_o       = 1'b0;
    burst_o      = '0;
    case (r_state)
      IDLE: begin
        if (write_i) begin
          w_state_next = WR_BURST;
        end else if (read_i) begin
          w_state_next = RD_BURST;
        end
      end
      RD_BURST: begin
        read_o = 1'b1;
        if (w_last_beat) begin
          w_state_next = DONE;
        end
      end
      WR_BURST: begin
        write_o = 1'b1;
        burst_o = r_line_wr[r_count*BURST_W +: BURST_W];
        if (w_last_beat) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        resp_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign line_o    = r_line_rd;
  assign address_o = r_addr;

endmodule : line_burst_adaptor
`default_nettype wire

// File: tb/tb_line_burst_adaptor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_burst_adaptor
//  Description : Directed self-checking bench for line_burst_adaptor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_line_burst_adaptor;

  logic         clk;
  logic         rst_n;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_vec;
  int n_err;
  int cyc;
  int last_resp_cyc;

  line_burst_adaptor u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point for every check.
  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Line fill: pat[i] is resp_i in the i-th burst cycle; the pattern must end on the 4th beat.
  task automatic mem_read(input string tag, input logic [31:0] addr, input logic [255:0] data,
                          input logic [15:0] pat, input int plen);
    int k;
    address_i = addr;
    read_i    = 1'b1;
    resp_i    = 1'b0;
    step();
    check_val({tag, " read_o"}, 256'(read_o), 256'(1'b1));
    check_val({tag, " address_o"}, 256'(address_o), 256'({addr[31:5], 5'b0}));
    k = 0;
    for (int i = 0; i < plen; i++) begin
      resp_i  = pat[i];
      burst_i = pat[i] ? data[64*k +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
      address_i = 32'hFFFF_FFFF;
      step();
      if (pat[i]) k++;
      if (k < 4) check_val({tag, " resp_o early"}, 256'(resp_o), 256'(1'b0));
    end
    resp_i = 1'b0;
    check_val({tag, " resp_o"}, 256'(resp_o), 256'(1'b1));
    check_val({tag, " read_o drop"}, 256'(read_o), 256'(1'b0));
    check_val({tag, " line_o"}, line_o, data);
    last_resp_cyc = cyc;
    read_i = 1'b0;
    step();
    check_val({tag, " resp_o pulse"}, 256'(resp_o), 256'(1'b0));
  endtask

  // Writeback, optionally with read_i also raised to exercise priority.
  task automatic mem_write(input string tag, input logic [31:0] addr, input logic [255:0] data,
                           input logic also_read, input logic [255:0] exp_line);
    address_i = addr;
    line_i    = data;
    write_i   = 1'b1;
    read_i    = also_read;
    resp_i    = 1'b0;
    step();
    check_val({tag, " write_o"}, 256'(write_o), 256'(1'b1));
    check_val({tag, " read_o"}, 256'(read_o), 256'(1'b0));
    check_val({tag, " address_o"}, 256'(address_o), 256'({addr[31:5], 5'b0}));
    line_i = '1;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("%s burst_o[%0d]", tag, k), 256'(burst_o), 256'(data[64*k +: 64]));
      resp_i = 1'b1;
      step();
    end
    resp_i = 1'b0;
    check_val({tag, " write_o drop"}, 256'(write_o), 256'(1'b0));
    check_val({tag, " resp_o"}, 256'(resp_o), 256'(1'b1));
    check_val({tag, " line_o kept"}, line_o, exp_line);
    last_resp_cyc = cyc;
    write_i = 1'b0;
    read_i  = 1'b0;
    step();
    check_val({tag, " resp_o pulse"}, 256'(resp_o), 256'(1'b0));
  endtask

  localparam logic [255:0] RD_A = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                                   64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
  localparam logic [255:0] RD_B = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                   64'h5555_AAAA_5555_AAAA, 64'h1111_2222_3333_4444};
  localparam logic [255:0] RD_C = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] WR_A = {64'h3030_3030_3030_3030, 64'h2020_2020_2020_2020,
                                   64'h1010_1010_1010_1010, 64'h0A0A_0A0A_0A0A_0A0A};
  localparam logic [255:0] WR_B = {64'h8000_0000_0000_0003, 64'h8000_0000_0000_0002,
                                   64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000};

  initial begin
    int gap;
    n_vec = 0; n_err = 0; cyc = 0; last_resp_cyc = 0;
    rst_n = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst line_o", line_o, 256'd0);
    check_val("rst burst_o", 256'(burst_o), 256'd0);
    check_val("rst address_o", 256'(address_o), 256'd0);
    check_val("rst read_o", 256'(read_o), 256'd0);
    check_val("rst write_o", 256'(write_o), 256'd0);
    check_val("rst resp_o", 256'(resp_o), 256'd0);
    rst_n = 1'b1;
    step();

    // Plain fill from the reference address
    mem_read("rd1", 32'h0000_1234, RD_A, 16'b1111, 4);
    // Writeback with read_i also high: write wins, line_o untouched
    mem_write("wr1", 32'h0000_5678, WR_A, 1'b1, RD_A);

    // Stray beats while idle
    resp_i = 1'b1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    step(); step();
    check_val("stray read_o", 256'(read_o), 256'd0);
    check_val("stray write_o", 256'(write_o), 256'd0);
    check_val("stray resp_o", 256'(resp_o), 256'd0);
    check_val("stray line_o", line_o, RD_A);
    resp_i = 1'b0;
    step();

    // Gapped beats 1,0,0,1,1,0,1
    mem_read("gap", 32'h0000_ABCD, RD_B, 16'b1011001, 7);

    // Evict flow: writeback then fill to a new address
    mem_write("evict wr", 32'h0000_2000, WR_B, 1'b0, RD_B);
    gap = last_resp_cyc;
    mem_read("evict rd", 32'h0000_3FFF, RD_C, 16'b1111, 4);
    gap = last_resp_cyc - gap;
    check_val("evict resp spacing>=6", 256'(gap >= 6), 256'(1'b1));

    // Reset after two read beats abandons the fill
    address_i = 32'h0000_7777; read_i = 1'b1; resp_i = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      resp_i = 1'b1; burst_i = 64'h7777_0000_0000_0000 + 64'(i);
      step();
    end
    rst_n = 1'b0;
    #1;
    check_val("midrst line_o", line_o, 256'd0);
    check_val("midrst read_o", 256'(read_o), 256'd0);
    check_val("midrst address_o", 256'(address_o), 256'd0);
    check_val("midrst resp_o", 256'(resp_o), 256'd0);
    read_i = 1'b0; resp_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check_val("postrst resp_o", 256'(resp_o), 256'd0);
    check_val("postrst read_o", 256'(read_o), 256'd0);
    mem_read("postrst rd", 32'h0000_1234, RD_A, 16'b1111, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_line_burst_adaptor
`default_nettype wire
